mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the core's data-memory bus, downstream of the core's store path.
- Decodes a two-word register window at BASE_ADDR and buffers written bytes in a FIFO.
- Serialises buffered bytes as 8N1 frames on a single TX pin.
- The top level muxes `rdata` into the load path whenever `sel` is high and gates memory WE off for that address window.

---
 rtl/mmio_uart_tx_if.sv | 12 +
 rtl/mmio_uart_tx.sv | 148 ++++++++++++++
 tb/tb_mmio_uart_tx.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus view of the UART transmitter's register window.
// The core side drives address/data/strobe; the peripheral returns decode and read data.
interface mmio_uart_tx_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        sel;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output we, input sel, input rdata);
  modport slave  (input addr, input wdata, input we, output sel, output rdata);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS window, byte FIFO and serialiser.
// The top level uses sel to steer rdata into the load path and to block memory writes.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic           clk,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state;
  logic [BW-1:0]   r_baud;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;
  logic [7:0]      r_mem [FIFO_DEPTH];

  logic            w_sel;
  logic            w_push;
  logic            w_clr;
  logic            w_full;
  logic            w_empty;
  logic            w_accept;
  logic            w_baud_last;
  logic            w_pop;
  logic [7:0]      w_head;
  logic [7:0]      w_count8;
  logic [31:0]     w_status;

  assign w_sel       = (bus.addr[31:3] == BASE_ADDR[31:3]);
  assign w_push      = bus.we && w_sel && !bus.addr[2];
  assign w_clr       = bus.we && w_sel && bus.addr[2] && bus.wdata[3];
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  // Full is judged on the pre-edge count, so a same-edge pop never rescues a push at full.
  assign w_accept    = w_push && !w_full;
  assign w_baud_last = (r_baud == BW'(CLKS_PER_BIT - 1));
  assign w_pop       = !w_empty && ((r_state == S_IDLE) || (r_state == S_STOP && w_baud_last));
  assign w_head      = r_mem[r_rd_ptr];
  assign w_count8    = 8'(r_count);

  assign w_status  = {16'h0000, w_count8, 4'h0, r_ovf, (r_state != S_IDLE), w_empty, w_full};
  assign bus.sel   = w_sel;
  assign bus.rdata = (w_sel && bus.addr[2]) ? w_status : 32'h0;
  assign tx        = r_tx;

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && w_full) r_ovf <= 1'b1;
      else if (w_clr)       r_ovf <= 1'b0;
    end
  end

  // tx is set alongside the state so the line level always matches the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= w_head;
            r_baud  <= '0;
            r_state <= S_START;
            r_tx    <= 1'b0;
          end
        end
        S_START: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_DATA: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_tx <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_STOP: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= w_head;
              r_state <= S_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: decode table, exact frame timing, FIFO/overflow,
// asynchronous reset mid-frame, with a byte scoreboard fed by pushes and drained by the line.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  logic tx;
  always #5 clk = ~clk;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .tx    (tx)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        exp_sel;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.we    = 1'b0;
    bus.addr  = BASE + 32'd4;
    bus.wdata = 32'h0;
  endtask

  task automatic read_status(output logic [31:0] v);
    bus.addr = BASE + 32'd4;
    #1;
    v = bus.rdata;
  endtask

  task automatic check_status(input string name, input logic [31:0] exp);
    logic [31:0] v;
    read_status(v);
    check(name, v, exp);
  endtask

  task automatic push(input logic [7:0] b, input bit track, input logic [31:0] a);
    bus.addr  = a;
    bus.wdata = {24'h0, b};
    bus.we    = 1'b1;
    if (track) exp_q.push_back(b);
    tick();
    bus_idle();
  endtask

  // Cycle-exact frame check: start bit must appear within budget ticks of the current sample.
  task automatic frame_exact(input int budget);
    logic [7:0] b;
    bit got;
    logic exp_tx;
    logic [31:0] st;
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard_empty: got 0 entries expected >=1");
      return;
    end
    b = exp_q.pop_front();
    got = 0;
    for (int k = 0; k <= budget; k++) begin
      if (k > 0) tick();
      if (tx === 1'b0) begin got = 1; break; end
    end
    check("frame_start", {31'h0, got}, 32'h1);
    if (!got) return;
    for (int i = 1; i <= 10 * CPB; i++) begin
      if (i > 1) tick();
      if (i <= CPB)          exp_tx = 1'b0;
      else if (i <= 9 * CPB) exp_tx = b[(i - CPB - 1) / CPB];
      else                   exp_tx = 1'b1;
      check($sformatf("tx_cycle%0d_byte%02h", i, b), {31'h0, tx}, {31'h0, exp_tx});
      read_status(st);
      check("busy_in_frame", {31'h0, st[2]}, 32'h1);
    end
    $display("frame %02h checked cycle by cycle", b);
  endtask

  // Mid-bit sampling receiver; compares against the scoreboard head.
  task automatic rx_byte(input int budget);
    logic prev;
    bit found;
    logic [7:0] r;
    logic [7:0] e;
    prev = tx;
    found = 0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (prev === 1'b1 && tx === 1'b0) begin found = 1; break; end
      prev = tx;
    end
    check("rx_start_seen", {31'h0, found}, 32'h1);
    if (!found) return;
    tick(); tick();
    check("rx_start_mid", {31'h0, tx}, 32'h0);
    for (int j = 0; j < 8; j++) begin
      repeat (CPB) tick();
      r[j] = tx;
    end
    repeat (CPB) tick();
    check("rx_stop_mid", {31'h0, tx}, 32'h1);
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL rx_scoreboard_empty: got %02h expected none", r);
      return;
    end
    e = exp_q.pop_front();
    check("rx_byte", {24'h0, r}, {24'h0, e});
    $display("rx byte %02h expected %02h", r, e);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    vt[0] = '{32'h0000_0100, 32'h0,         1'b0, 1'b0, 32'h0};
    vt[1] = '{BASE + 32'd4,  32'h0,         1'b0, 1'b1, 32'h0000_0002};
    vt[2] = '{BASE + 32'd8,  32'h55,        1'b1, 1'b0, 32'h0};
    vt[3] = '{32'hFFFE_FFFC, 32'h55,        1'b1, 1'b0, 32'h0};
    vt[4] = '{BASE,          32'h0,         1'b0, 1'b1, 32'h0};
    vt[5] = '{BASE + 32'd5,  32'h0,         1'b0, 1'b1, 32'h0000_0002};
    vt[6] = '{BASE + 32'd4,  32'hFFFF_FFF7, 1'b1, 1'b1, 32'h0000_0002};

    reset = 1'b0;
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    check("tx_in_reset", {31'h0, tx}, 32'h1);
    reset = 1'b1;
    tick();
    check("tx_after_reset", {31'h0, tx}, 32'h1);
    check_status("status_after_reset", 32'h0000_0002);

    for (int i = 0; i < 7; i++) begin
      bus.addr  = vt[i].addr;
      bus.wdata = vt[i].wdata;
      bus.we    = vt[i].we;
      #1;
      check($sformatf("vec%0d_sel", i), {31'h0, bus.sel}, {31'h0, vt[i].exp_sel});
      check($sformatf("vec%0d_rdata", i), bus.rdata, vt[i].exp_rdata);
      tick();
      bus_idle();
      $display("vector %0d addr=%h we=%0d applied", i, vt[i].addr, vt[i].we);
    end
    tick();
    check_status("decode_count_zero", 32'h0000_0002);
    check("decode_tx_idle", {31'h0, tx}, 32'h1);

    push(8'h5A, 1, BASE + 32'd2);
    check_status("alias_push_count", 32'h0000_0100);
    rx_byte(10);
    tick(); tick();
    check_status("alias_idle", 32'h0000_0002);

    push(8'hA5, 1, BASE);
    check("a5_tx_before_start", {31'h0, tx}, 32'h1);
    check_status("a5_count1", 32'h0000_0100);
    frame_exact(1);
    tick();
    check("a5_tx_after", {31'h0, tx}, 32'h1);
    check_status("a5_busy_dropped", 32'h0000_0002);

    push(8'h01, 1, BASE);
    check_status("b2b_count_after_first", 32'h0000_0100);
    push(8'h80, 1, BASE);
    check_status("b2b_push_with_pop", 32'h0000_0104);
    frame_exact(0);
    check_status("b2b_count_before_second", 32'h0000_0104);
    frame_exact(1);
    check_status("b2b_count_drained", 32'h0000_0006);
    tick();
    check_status("b2b_idle", 32'h0000_0002);

    push(8'hFF, 0, BASE);
    for (int i = 2; i <= 10; i++) push(8'(8'h10 + i), (i <= 9), BASE);
    check_status("ovf_full", 32'h0000_080D);
    bus.addr  = BASE + 32'd4;
    bus.wdata = 32'h8;
    bus.we    = 1'b1;
    tick();
    bus_idle();
    check_status("ovf_cleared", 32'h0000_0805);
    for (int i = 0; i < 8; i++) rx_byte(60);
    tick(); tick();
    check_status("ovf_drained", 32'h0000_0002);

    push(8'hF0, 1, BASE);
    repeat (18) tick();
    check("midframe_bit3_low", {31'h0, tx}, 32'h0);
    reset = 1'b0;
    #1;
    check("async_reset_tx", {31'h0, tx}, 32'h1);
    check_status("async_reset_status", 32'h0000_0002);
    exp_q.delete();
    tick(); tick();
    reset = 1'b1;
    tick();
    check_status("post_reset_status", 32'h0000_0002);
    check("post_reset_tx", {31'h0, tx}, 32'h1);
    push(8'h3C, 1, BASE);
    frame_exact(1);
    tick();
    check_status("post_reset_idle", 32'h0000_0002);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
